// File: rtl/rrobin_pkg.sv
// Shared types and sizing helpers for the round-robin arbiter slice.
package rrobin_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   localparam int unsigned DEF_N        = 4;
   localparam int unsigned DEF_MAX_HOLD = 1;

   // Bits needed to hold values 0..count-1, never less than one.
   function automatic int unsigned idx_width(input int unsigned count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set bit of req & ~excl,
// scanning upward from start and wrapping at N.
module rr_pick
   import rrobin_pkg::*;
#(
   parameter int unsigned N  = DEF_N,
   parameter int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] start_i,
   input  logic [N-1:0]  excl_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   logic [N-1:0]  cand;
   logic [IW-1:0] pos;

   always_comb begin
      cand    = req_i & ~excl_i;
      found_o = 1'b0;
      idx_o   = '0;
      pos     = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = IW'((32'(start_i) + k) % N);
         if (!found_o && cand[pos]) begin
            found_o = 1'b1;
            idx_o   = pos;
         end
      end
   end

endmodule

// File: rtl/rrobin_arb_n.sv
// N-channel round-robin arbiter with registered grant and a per-owner hold
// budget of MAX_HOLD cycles while other channels are waiting.
module rrobin_arb_n
   import rrobin_pkg::*;
#(
   parameter int unsigned N        = DEF_N,
   parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [N-1:0]         ir,
   output logic [N-1:0]         ack,
   output logic [$clog2(N)-1:0] ack_id,
   output logic                 busy
);

   localparam int unsigned   IW       = idx_width(N);
   localparam int unsigned   HW       = idx_width(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   state_e        state_q, state_d;
   logic [N-1:0]  req_q;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [N-1:0]  ack_q, ack_d;
   logic [IW-1:0] id_q, id_d;
   logic          busy_q, busy_d;

   logic [N-1:0]  owner_mask;
   logic [N-1:0]  others;
   logic          owner_req;
   logic [IW-1:0] start;
   logic [N-1:0]  excl;
   logic          pick_found;
   logic [IW-1:0] pick_idx;

   assign owner_mask = N'(1) << ptr_q;
   assign owner_req  = |(req_q & owner_mask);
   assign others     = req_q & ~owner_mask;
   assign start      = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + IW'(1);
   // Masking the owner only matters when its hold budget is spent; when the
   // owner is not requesting the mask is a no-op, and in IDLE ptr is eligible.
   assign excl       = (state_q == GRANT) ? owner_mask : '0;

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req_i   (req_q),
      .start_i (start),
      .excl_i  (excl),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      if (req_q == '0) begin
         state_d = IDLE;
         hold_d  = '0;
      end else begin
         state_d = GRANT;
         if (state_q == GRANT && owner_req && (others == '0 || hold_q < HOLD_MAX)) begin
            if (hold_q < HOLD_MAX) begin
               hold_d = hold_q + HW'(1);
            end
         end else if (pick_found) begin
            ptr_d  = pick_idx;
            hold_d = HW'(1);
         end
      end
      ack_d  = (state_d == GRANT) ? (N'(1) << ptr_d) : '0;
      id_d   = (state_d == GRANT) ? ptr_d : '0;
      busy_d = (state_d == GRANT);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         ptr_q   <= IW'(N - 1);
         hold_q  <= '0;
         ack_q   <= '0;
         id_q    <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= ir;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         ack_q   <= ack_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
      end
   end

   assign ack    = ack_q;
   assign ack_id = id_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_rrobin_arb_n.sv
// Bench for rrobin_arb_n: N=4/MAX_HOLD=2 and N=2/MAX_HOLD=1 instances checked
// against a rule-level model every cycle plus directed literal expectations.
module tb_rrobin_arb_n;

   logic       clock;
   logic       reset;
   logic [3:0] ir_a, ack_a;
   logic [1:0] ack_id_a;
   logic       busy_a;
   logic [1:0] ir_b, ack_b;
   logic [0:0] ack_id_b;
   logic       busy_b;

   int checks = 0;
   int passes = 0;

   rrobin_arb_n #(.N(4), .MAX_HOLD(2)) dut_a (
      .clock (clock), .reset (reset), .ir (ir_a),
      .ack (ack_a), .ack_id (ack_id_a), .busy (busy_a)
   );

   rrobin_arb_n #(.N(2), .MAX_HOLD(1)) dut_b (
      .clock (clock), .reset (reset), .ir (ir_b),
      .ack (ack_b), .ack_id (ack_id_b), .busy (busy_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else passes++;
   endtask

   task automatic check_le(input string name, input int act, input int lim);
      checks++;
      if (act > lim) $display("FAIL %s: waited %0d cycles, limit %0d at %0t", name, act, lim, $time);
      else passes++;
   endtask

   // Model: per instance, the latched request word, the current owner (or the
   // last owner while idle), whether a grant is active and the owner's tenure.
   int mreq [2];
   int mown [2];
   int mhold[2];
   bit mbusy[2];
   bit armed = 1'b0;
   int wait_a[4];
   int wait_b[2];

   function automatic void mstep(input int i, input int n, input int mh, input int irv, input bit rst);
      int  r;
      int  c;
      bit  own_on;
      bit  rivals;
      if (rst) begin
         mreq[i] = 0; mown[i] = n - 1; mbusy[i] = 1'b0; mhold[i] = 0;
         return;
      end
      r       = mreq[i];
      mreq[i] = irv;
      if (r == 0) begin
         mbusy[i] = 1'b0;
         mhold[i] = 0;
      end else begin
         own_on = mbusy[i] && (((r >> mown[i]) & 1) != 0);
         rivals = (r & ~(1 << mown[i])) != 0;
         if (own_on && (!rivals || mhold[i] < mh)) begin
            mhold[i] = (mhold[i] < mh) ? mhold[i] + 1 : mh;
         end else begin
            for (int k = 1; k <= n; k++) begin
               c = (mown[i] + k) % n;
               if ((((r >> c) & 1) != 0) && !(own_on && c == mown[i])) begin
                  mown[i] = c;
                  break;
               end
            end
            mbusy[i] = 1'b1;
            mhold[i] = 1;
         end
      end
   endfunction

   always @(posedge clock) begin
      mstep(0, 4, 2, int'(ir_a), reset);
      mstep(1, 2, 1, int'(ir_b), reset);
      if (reset) armed = 1'b1;
   end

   always @(negedge clock) begin
      if (armed) begin
         check("m_ack_a",  32'(ack_a),    mbusy[0] ? (1 << mown[0]) : 0);
         check("m_id_a",   32'(ack_id_a), mbusy[0] ? mown[0] : 0);
         check("m_busy_a", 32'(busy_a),   32'(mbusy[0]));
         check("m_ack_b",  32'(ack_b),    mbusy[1] ? (1 << mown[1]) : 0);
         check("m_id_b",   32'(ack_id_b), mbusy[1] ? mown[1] : 0);
         check("m_busy_b", 32'(busy_b),   32'(mbusy[1]));
         check("onehot_a", 32'($onehot0(ack_a)), 1);
         check("onehot_b", 32'($onehot0(ack_b)), 1);
         for (int c = 0; c < 4; c++) begin
            if ((((mreq[0] >> c) & 1) != 0) && !ack_a[c]) wait_a[c]++;
            else wait_a[c] = 0;
            check_le("starve_a", wait_a[c], 3 * 2 + 1);
         end
         for (int c = 0; c < 2; c++) begin
            if ((((mreq[1] >> c) & 1) != 0) && !ack_b[c]) wait_b[c]++;
            else wait_b[c] = 0;
            check_le("starve_b", wait_b[c], 1 * 1 + 1);
         end
      end
   end

   logic [3:0] rot_exp [9]  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                                4'b0100, 4'b1000, 4'b1000, 4'b0001};
   logic [3:0] a_exp   [10] = '{4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
   logic [1:0] b_exp   [10] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10,
                                2'b01, 2'b01, 2'b01, 2'b01, 2'b00};

   initial begin
      reset = 1'b1; ir_a = '0; ir_b = '0;
      repeat (3) @(negedge clock);
      check("rst_ack_a",  32'(ack_a), 0);
      check("rst_id_a",   32'(ack_id_a), 0);
      check("rst_busy_a", 32'(busy_a), 0);
      check("rst_ack_b",  32'(ack_b), 0);
      reset = 1'b0;

      for (int k = 0; k < 5; k++) begin
         @(negedge clock);
         check("idle_ack",  32'(ack_a), 0);
         check("idle_busy", 32'(busy_a), 0);
      end

      ir_a = 4'b0100;
      @(negedge clock); check("lat1_ack", 32'(ack_a), 0);
      @(negedge clock); check("lat2_ack", 32'(ack_a), 4'b0100);
      check("lat2_id", 32'(ack_id_a), 2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock); check("held_id", 32'(ack_id_a), 2);
      end

      ir_a = '0; reset = 1'b1;
      @(negedge clock);
      reset = 1'b0; ir_a = 4'b1111;
      @(negedge clock); check("rot_lat", 32'(ack_a), 0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clock); check("rot_seq", 32'(ack_a), 32'(rot_exp[k]));
      end

      ir_a = 4'b1000;
      @(negedge clock);
      @(negedge clock); check("own3", 32'(ack_a), 4'b1000);
      ir_a = 4'b0011;
      @(negedge clock); check("own3_hold", 32'(ack_a), 4'b1000);
      @(negedge clock); check("wrap_to0", 32'(ack_a), 4'b0001);

      @(negedge clock); check("pre_rst0", 32'(ack_a), 4'b0001);
      @(negedge clock); check("pre_rst1", 32'(ack_a), 4'b0010);
      reset = 1'b1;
      @(negedge clock);
      check("mid_rst_ack",  32'(ack_a), 0);
      check("mid_rst_busy", 32'(busy_a), 0);
      check("mid_rst_id",   32'(ack_id_a), 0);
      reset = 1'b0; ir_a = 4'b1111; ir_b = 2'b11;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         check("post_rst_a", 32'(ack_a), 32'(a_exp[k]));
         check("toggle_b",   32'(ack_b), 32'(b_exp[k]));
         if (k == 4) ir_b = 2'b01;
         if (k == 7) ir_b = 2'b00;
      end

      for (int k = 0; k < 10000; k++) begin
         @(negedge clock);
         ir_a = 4'($urandom() | $urandom() | $urandom());
         ir_b = 2'($urandom() | $urandom());
      end

      @(negedge clock);
      #2;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rrobin_arb_n.md
RROBIN_ARB_N -- requirements
Module: rrobin_arb_n

Interface
REQ-001 Parameter N SHALL have default 4 and set the requester channel count; legal range is 2..16.
REQ-002 Parameter MAX_HOLD SHALL have default 1 and set the number of consecutive grant cycles allowed while another channel waits; legal range is 1..255.
REQ-003 Port clock SHALL be an input, 1 bit: the single clock; all state changes on its posedge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port ir SHALL be an input, N bits: raw request per channel, sampled every posedge.
REQ-006 Port ack SHALL be an output, N bits, registered: grant per channel, one-hot or zero.
REQ-007 Port ack_id SHALL be an output, $clog2(N) bits, registered: index of the granted channel; 0 when ack is zero.
REQ-008 Port busy SHALL be an output, 1 bit, registered: high when |ack is high.

Function
REQ-009 The block SHALL latch ir into an internal req register on every posedge; ack SHALL be computed from the pre-edge req value, so the ir-to-ack latency is 2 posedges.
REQ-010 ack SHALL never have more than one bit set (mutual exclusion, every cycle).
REQ-011 The FSM SHALL have two states, IDLE (no grant) and GRANT (one channel owns ack).
REQ-012 IDLE with req==0 SHALL stay IDLE with ack=0.
REQ-013 IDLE or GRANT with the owner's req low and some req high SHALL grant the first requesting channel found scanning upward from ptr+1 modulo N; ptr SHALL then become that index and hold_cnt SHALL be 1.
REQ-014 GRANT with the owner's req high and no other req high SHALL keep the owner indefinitely; hold_cnt SHALL saturate at MAX_HOLD.
REQ-015 GRANT with the owner's req high, another req high and hold_cnt<MAX_HOLD SHALL keep the owner and increment hold_cnt.
REQ-016 GRANT with the owner's req high, another req high and hold_cnt>=MAX_HOLD SHALL pass the grant by the REQ-013 scan, excluding the owner. With N=2 and MAX_HOLD=1 this gives an alternating toggle.
REQ-017 GRANT with req==0 SHALL return to IDLE with ack=0 next cycle; ptr SHALL be retained.
REQ-018 Simultaneous new requests from IDLE SHALL be resolved only by rotating priority from ptr+1, with no fixed-index bias.
REQ-019 Wrap-around: a scan from ptr=N-1 SHALL begin at channel 0.
REQ-020 Starvation bound: a channel with req continuously high SHALL be granted within (N-1)*MAX_HOLD+1 cycles.
REQ-021 hold_cnt SHALL be $clog2(MAX_HOLD+1) bits wide, unsigned, and SHALL never wrap.

Reset
REQ-022 When reset is high at a posedge: req=0, ack=0, ack_id=0, busy=0, hold_cnt=0, ptr=N-1, state=IDLE.
REQ-023 Reset asserted mid-grant SHALL drop ack on that same edge; the first grant after reset SHALL be scanned from channel 0.
REQ-024 While reset is high, ir SHALL be ignored; the first ir sample SHALL be taken at the first posedge with reset low.

Structure
REQ-025 Package rrobin_pkg SHALL hold the state enum (IDLE, GRANT), the default N and MAX_HOLD constants, and a width helper for ack_id and hold_cnt.
REQ-026 Sub-module rr_pick SHALL be a combinational rotating-priority picker with inputs (req vector, start index, exclude mask) and outputs (found, index).
REQ-027 All sequential state SHALL live in rrobin_arb_n.

Verification (N=4, MAX_HOLD=2 unless stated)
REQ-028 Reset, then ir=4'b0000 for 5 cycles -> ack=0 and busy=0 throughout.
REQ-029 ir=4'b0100 held -> ack=4'b0100 and ack_id=2 at the 2nd posedge after ir is applied; ack_id=2 retained while ir is held.
REQ-030 ir=4'b1111 held from IDLE after reset -> ack sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001 (wrap).
REQ-031 With N=2, MAX_HOLD=1 and ir=2'b11 held -> ack alternates 01,10,01,...; with ir=2'b01 -> ack=01 steady; with ir=2'b00 -> ack=00 one cycle later.
REQ-032 Owner channel 3 drops its request while ir=4'b0011 -> next grant goes to channel 0 (wrap), not channel 1.
REQ-033 Reset pulsed while ack=4'b0010 -> ack=0 at that edge; ir=4'b1111 afterwards -> first grant 0001; random ir for 10k cycles -> REQ-010 and REQ-020 hold.
